// File: rtl/dmi_req_arbiter.sv
// Arbitrates JTAG and system-side register requests onto one debug-module port.
// One transaction is outstanding at a time, with round-robin grant and a response timeout.
module dmi_req_arbiter #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // JTAG side
  input  logic              j_reg_en,
  input  logic              j_reg_wr_en,
  input  logic [ADDR_W-1:0] j_addr,
  input  logic [31:0]       j_wdata,
  output logic              j_busy,
  output logic              j_done,
  output logic [31:0]       j_rdata,
  output logic              j_err,
  output logic              j_overrun,
  // system side
  input  logic              s_req_valid,
  output logic              s_req_ready,
  input  logic              s_req_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_rsp_valid,
  output logic [31:0]       s_rdata,
  output logic              s_rsp_err,
  // debug module side
  output logic              dm_req,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_rsp_valid,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_J = 1'b0,
    OWN_S = 1'b1
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                rr_q, rr_d;              // 1: system is favoured on contention
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                j_pend_q, j_pend_d;
  logic                j_pwr_q, j_pwr_d;
  logic [ADDR_W-1:0]   j_paddr_q, j_paddr_d;
  logic [31:0]         j_pwdata_q, j_pwdata_d;
  logic                j_overrun_q, j_overrun_d;
  logic                j_busy_q, j_busy_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_wr_q, dm_wr_d;
  logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
  logic [31:0]         dm_wdata_q, dm_wdata_d;
  logic                j_done_q, j_done_d;
  logic [31:0]         j_rdata_q, j_rdata_d;
  logic                j_err_q, j_err_d;
  logic                s_rsp_valid_q, s_rsp_valid_d;
  logic [31:0]         s_rdata_q, s_rdata_d;
  logic                s_rsp_err_q, s_rsp_err_d;

  logic                j_acc_c;
  logic                j_req_c;
  logic                s_wins_c;
  logic                gnt_j_c;
  logic                gnt_s_c;
  logic                rsp_fire_c;
  logic [31:0]         rsp_data_c;
  logic                rsp_err_c;

  // An arriving JTAG pulse takes part in arbitration so it is not overtaken by a
  // simultaneous system request; it is granted from j_pend on the following cycle.
  always_comb begin
    j_acc_c  = j_reg_en & ~j_busy_q;
    j_req_c  = j_pend_q | j_acc_c;
    s_wins_c = s_req_valid & (~j_req_c | rr_q);
    gnt_s_c  = (state_q == IDLE) & s_wins_c;
    gnt_j_c  = (state_q == IDLE) & j_pend_q & ~s_wins_c;
  end

  assign s_req_ready = gnt_s_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    dm_wr_d       = dm_wr_q;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    j_done_d      = 1'b0;
    j_rdata_d     = j_rdata_q;
    j_err_d       = j_err_q;
    s_rsp_valid_d = 1'b0;
    s_rdata_d     = s_rdata_q;
    s_rsp_err_d   = s_rsp_err_q;
    rsp_fire_c    = 1'b0;
    rsp_data_c    = '0;
    rsp_err_c     = 1'b0;

    j_pend_d    = j_acc_c | (j_pend_q & ~gnt_j_c);
    j_pwr_d     = j_acc_c ? j_reg_wr_en : j_pwr_q;
    j_paddr_d   = j_acc_c ? j_addr      : j_paddr_q;
    j_pwdata_d  = j_acc_c ? j_wdata     : j_pwdata_q;
    j_overrun_d = j_overrun_q | (j_reg_en & j_busy_q);

    unique case (state_q)
      IDLE: begin
        if (gnt_j_c) begin
          owner_d    = OWN_J;
          rr_d       = 1'b1;
          dm_wr_d    = j_pwr_q;
          dm_addr_d  = j_paddr_q;
          dm_wdata_d = j_pwdata_q;
          state_d    = ISSUE;
        end else if (gnt_s_c) begin
          owner_d    = OWN_S;
          rr_d       = 1'b0;
          dm_wr_d    = s_req_wr;
          dm_addr_d  = s_addr;
          dm_wdata_d = s_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a response on the timeout cycle still counts as a normal response
        if (dm_rsp_valid) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = dm_rdata;
          rsp_err_c  = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = '0;
          rsp_err_c  = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_fire_c) begin
      if (owner_q == OWN_J) begin
        j_done_d  = 1'b1;
        j_rdata_d = rsp_data_c;
        j_err_d   = rsp_err_c;
      end else begin
        s_rsp_valid_d = 1'b1;
        s_rdata_d     = rsp_data_c;
        s_rsp_err_d   = rsp_err_c;
      end
    end

    dm_req_d = (state_d == ISSUE);
    j_busy_d = j_pend_d | ((owner_d == OWN_J) & (state_d != IDLE));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_J;
      rr_q          <= 1'b0;
      cnt_q         <= '0;
      j_pend_q      <= 1'b0;
      j_pwr_q       <= 1'b0;
      j_paddr_q     <= '0;
      j_pwdata_q    <= '0;
      j_overrun_q   <= 1'b0;
      j_busy_q      <= 1'b0;
      dm_req_q      <= 1'b0;
      dm_wr_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      j_done_q      <= 1'b0;
      j_rdata_q     <= '0;
      j_err_q       <= 1'b0;
      s_rsp_valid_q <= 1'b0;
      s_rdata_q     <= '0;
      s_rsp_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      j_pend_q      <= j_pend_d;
      j_pwr_q       <= j_pwr_d;
      j_paddr_q     <= j_paddr_d;
      j_pwdata_q    <= j_pwdata_d;
      j_overrun_q   <= j_overrun_d;
      j_busy_q      <= j_busy_d;
      dm_req_q      <= dm_req_d;
      dm_wr_q       <= dm_wr_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      j_done_q      <= j_done_d;
      j_rdata_q     <= j_rdata_d;
      j_err_q       <= j_err_d;
      s_rsp_valid_q <= s_rsp_valid_d;
      s_rdata_q     <= s_rdata_d;
      s_rsp_err_q   <= s_rsp_err_d;
    end
  end

  assign j_busy      = j_busy_q;
  assign j_done      = j_done_q;
  assign j_rdata     = j_rdata_q;
  assign j_err       = j_err_q;
  assign j_overrun   = j_overrun_q;
  assign s_rsp_valid = s_rsp_valid_q;
  assign s_rdata     = s_rdata_q;
  assign s_rsp_err   = s_rsp_err_q;
  assign dm_req      = dm_req_q;
  assign dm_wr       = dm_wr_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Bench for dmi_req_arbiter: vector table of single transactions plus hand-written
// sequences for arbitration, overrun and mid-transaction reset; responses go through a scoreboard.
module tb_dmi_req_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          j_reg_en, j_reg_wr_en;
  logic [AW-1:0] j_addr;
  logic [31:0]   j_wdata;
  logic          j_busy, j_done, j_err, j_overrun;
  logic [31:0]   j_rdata;
  logic          s_req_valid, s_req_ready, s_req_wr;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic          s_rsp_valid, s_rsp_err;
  logic [31:0]   s_rdata;
  logic          dm_req, dm_wr;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_rsp_valid;
  logic [31:0]   dm_rdata;

  dmi_req_arbiter #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .j_reg_en(j_reg_en), .j_reg_wr_en(j_reg_wr_en), .j_addr(j_addr), .j_wdata(j_wdata),
    .j_busy(j_busy), .j_done(j_done), .j_rdata(j_rdata), .j_err(j_err), .j_overrun(j_overrun),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_wr(s_req_wr),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata), .s_rsp_err(s_rsp_err),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sys;
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          delay;      // cycles after dm_req that the DM answers; 255 = never
    logic [31:0] dm_data;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;    // cycles from dm_req to the owner's response pulse
  } vec_t;

  typedef struct {
    bit          owner;      // 0 = JTAG, 1 = system
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   dm_cnt = 0;
  int   pulses = 0;
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every owner response pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_req) dm_cnt++;
      if (j_done || s_rsp_valid) begin
        pulses++;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rsp actual j_done=%0b s_rsp_valid=%0b expected none (cycle %0d)",
                   j_done, s_rsp_valid, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_owner", {31'd0, s_rsp_valid}, {31'd0, mon_e.owner});
          chk("rsp_both", {31'd0, j_done & s_rsp_valid}, 32'd0);
          chk("rsp_rdata", mon_e.owner ? s_rdata : j_rdata, mon_e.rdata);
          chk("rsp_err", {31'd0, mon_e.owner ? s_rsp_err : j_err}, {31'd0, mon_e.err});
          chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic wait_dm(output int d);
    d = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dm_req === 1'b1) begin
        d = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL dm_req_timeout actual=none expected=dm_req (cycle %0d)", cyc);
  endtask

  task automatic drive_rsp(input int delay, input logic [31:0] data);
    if (delay > 0) begin
      repeat (delay) @(posedge clk);
      #1;
    end
    dm_rsp_valid = 1'b1;
    dm_rdata     = data;
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0;
    dm_rdata     = '0;
  endtask

  task automatic wait_sb_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk); #2;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_j_busy"},      {31'd0, j_busy},      32'd0);
    chk({tag, "_j_done"},      {31'd0, j_done},      32'd0);
    chk({tag, "_j_rdata"},     j_rdata,              32'd0);
    chk({tag, "_j_err"},       {31'd0, j_err},       32'd0);
    chk({tag, "_j_overrun"},   {31'd0, j_overrun},   32'd0);
    chk({tag, "_s_req_ready"}, {31'd0, s_req_ready}, 32'd0);
    chk({tag, "_s_rsp_valid"}, {31'd0, s_rsp_valid}, 32'd0);
    chk({tag, "_s_rdata"},     s_rdata,              32'd0);
    chk({tag, "_s_rsp_err"},   {31'd0, s_rsp_err},   32'd0);
    chk({tag, "_dm_req"},      {31'd0, dm_req},      32'd0);
    chk({tag, "_dm_wr"},       {31'd0, dm_wr},       32'd0);
    chk({tag, "_dm_addr"},     32'(dm_addr),         32'd0);
    chk({tag, "_dm_wdata"},    dm_wdata,             32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int c0, d, dm0;
    dm0 = dm_cnt;
    @(posedge clk); #1;
    c0 = cyc;
    if (v.sys) begin
      s_req_valid = 1'b1; s_req_wr = v.wr; s_addr = v.addr; s_wdata = v.wdata;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (s_req_ready) break;
      end
      chk("s_grant_cycle", 32'(cyc), 32'(c0));
      @(posedge clk); #1;
      s_req_valid = 1'b0;
    end else begin
      j_reg_en = 1'b1; j_reg_wr_en = v.wr; j_addr = v.addr; j_wdata = v.wdata;
      @(posedge clk); #1;
      j_reg_en = 1'b0; j_reg_wr_en = 1'b0;
    end
    wait_dm(d);
    chk("req_to_dm_lat", 32'(d - c0), v.sys ? 32'd1 : 32'd2);
    chk("dm_wr",    {31'd0, dm_wr}, {31'd0, v.wr});
    chk("dm_addr",  32'(dm_addr),   32'(v.addr));
    chk("dm_wdata", dm_wdata,       v.wdata);
    sb.push_back('{owner: v.sys, rdata: v.exp_rdata, err: v.exp_err, cyc: d + v.exp_lat});
    if (v.delay != 255) drive_rsp(v.delay, v.dm_data);
    wait_sb_empty();
    chk("dm_req_count", 32'(dm_cnt - dm0), 32'd1);
    if (!v.sys) chk("j_busy_after", {31'd0, j_busy}, 32'd0);
  endtask

  initial begin
    int d, dm0, p0;
    rst_n = 1'b0;
    j_reg_en = 0; j_reg_wr_en = 0; j_addr = '0; j_wdata = '0;
    s_req_valid = 0; s_req_wr = 0; s_addr = '0; s_wdata = '0;
    dm_rsp_valid = 0; dm_rdata = '0;

    //             sys  wr   addr   wdata         dly  dm_data        exp_rdata     err  lat
    vecs[0] = '{1'b0, 1'b0, 7'h11, 32'h0,        3,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
    vecs[1] = '{1'b1, 1'b1, 7'h10, 32'h1,        255, 32'h0,        32'h0,        1'b1, 6};
    vecs[2] = '{1'b0, 1'b1, 7'h05, 32'h12345678, 1,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b0, 7'h7F, 32'h0,        5,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 6};
    vecs[4] = '{1'b0, 1'b0, 7'h00, 32'h0,        0,   32'h55555555, 32'h0,        1'b1, 6};
    vecs[5] = '{1'b1, 1'b0, 7'h22, 32'h0,        2,   32'h0BADF00D, 32'h0BADF00D, 1'b0, 3};
    vecs[6] = '{1'b0, 1'b0, 7'h33, 32'h0,        6,   32'h77777777, 32'h0,        1'b1, 6};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous requests after reset, then continuous re-requesting: strict alternation
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!j_busy) break;
          end
          @(posedge clk); #1;
          j_reg_en = 1'b1; j_reg_wr_en = 1'b0; j_addr = 7'(8'h40 + i); j_wdata = '0;
          @(posedge clk); #1;
          j_reg_en = 1'b0;
        end
      end
      begin
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          s_req_valid = 1'b1; s_req_wr = 1'b0; s_addr = 7'(8'h20 + i); s_wdata = '0;
          for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (s_req_ready) break;
          end
          @(posedge clk); #1;
        end
        s_req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          int dk;
          logic [6:0] ea;
          wait_dm(dk);
          ea = (k % 2 == 0) ? 7'(8'h40 + k / 2) : 7'(8'h20 + k / 2);
          chk("rr_order_addr", 32'(dm_addr), 32'(ea));
          sb.push_back('{owner: (k % 2 == 1), rdata: 32'hA000_0000 + 32'(k), err: 1'b0, cyc: dk + 3});
          drive_rsp(2, 32'hA000_0000 + 32'(k));
        end
      end
    join
    wait_sb_empty();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Second JTAG pulse while the first is outstanding: dropped, sticky overrun
    chk("overrun_before", {31'd0, j_overrun}, 32'd0);
    dm0 = dm_cnt;
    @(posedge clk); #1;
    j_reg_en = 1'b1; j_reg_wr_en = 1'b0; j_addr = 7'h15; j_wdata = '0;
    @(posedge clk); #1;
    j_reg_en = 1'b0;
    wait_dm(d);
    chk("ovr_dm_addr", 32'(dm_addr), 32'h15);
    sb.push_back('{owner: 1'b0, rdata: 32'h11112222, err: 1'b0, cyc: d + 5});
    @(posedge clk); #1;
    j_reg_en = 1'b1; j_reg_wr_en = 1'b1;
    @(posedge clk); #1;
    j_reg_en = 1'b0; j_reg_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dm_rsp_valid = 1'b1; dm_rdata = 32'h11112222;
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0; dm_rdata = '0;
    wait_sb_empty();
    chk("overrun_set", {31'd0, j_overrun}, 32'd1);
    repeat (6) @(negedge clk);
    chk("ovr_dm_req_count", 32'(dm_cnt - dm0), 32'd1);
    chk("ovr_j_busy", {31'd0, j_busy}, 32'd0);
    chk("ovr_dm_addr_hold", 32'(dm_addr), 32'h15);
    chk("ovr_dm_wr_hold", {31'd0, dm_wr}, 32'd0);
    chk("ovr_j_rdata_hold", j_rdata, 32'h11112222);
    chk("ovr_overrun_sticky", {31'd0, j_overrun}, 32'd1);

    // Reset during WAIT, then a late DM response: nothing delivered, all outputs 0
    @(posedge clk); #1;
    j_reg_en = 1'b1; j_addr = 7'h2A;
    @(posedge clk); #1;
    j_reg_en = 1'b0;
    wait_dm(d);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    p0  = pulses;
    dm0 = dm_cnt;
    dm_rsp_valid = 1'b1; dm_rdata = 32'h99999999;
    @(posedge clk); #1;
    dm_rsp_valid = 1'b0; dm_rdata = '0;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_no_pulse", 32'(pulses - p0), 32'd0);
    chk("rst_no_dm_req", 32'(dm_cnt - dm0), 32'd0);
    check_all_zero("midrst");

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmi_req_arbiter.md
DMI_REQ_ARBITER -- requirements
Module: dmi_req_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, giving the debug-module register address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait for a debug-module response in clk cycles (8-bit counter, legal range 1..255).
REQ-003 The block SHALL provide port clk, input, 1, core clock; all logic is on posedge clk.
REQ-004 The block SHALL provide port rst_n, input, 1; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 The block SHALL provide j_reg_en, input, 1: single-cycle request pulse from the JTAG-to-core synchronizer.
REQ-006 The block SHALL provide j_reg_wr_en, input, 1: write qualifier, valid with j_reg_en.
REQ-007 The block SHALL provide j_addr (input, ADDR_W) and j_wdata (input, 32): stable while j_busy=1.
REQ-008 The block SHALL provide j_busy (output, 1), j_done (output, 1, pulse), j_rdata (output, 32) and j_err (output, 1).
REQ-009 The block SHALL provide j_overrun, output, 1: sticky, set when j_reg_en arrives while a JTAG request is already pending.
REQ-010 The block SHALL provide s_req_valid/s_req_ready (input/output, 1), s_req_wr (input, 1), s_addr (input, ADDR_W) and s_wdata (input, 32): system-side request port.
REQ-011 The block SHALL provide s_rsp_valid (output, 1, pulse), s_rdata (output, 32) and s_rsp_err (output, 1).
REQ-012 The block SHALL provide dm_req (output, 1, pulse), dm_wr (output, 1), dm_addr (output, ADDR_W) and dm_wdata (output, 32): debug-module request.
REQ-013 The block SHALL provide dm_rsp_valid (input, 1) and dm_rdata (input, 32): debug-module response, returned for both reads and writes.

Function
REQ-014 The j_reg_en pulse SHALL set a pending flag j_pend, which is cleared on the cycle the JTAG request is granted; if set and clear coincide, set wins.
REQ-015 j_busy SHALL equal j_pend OR (an outstanding transaction owned by JTAG).
REQ-016 j_reg_en while j_busy=1 SHALL be dropped, SHALL set j_overrun, and SHALL NOT alter pending data.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and WAIT; the reset state is IDLE.
REQ-018 IDLE: if j_pend or s_req_valid, the FSM SHALL grant one requester, latch wr/addr/wdata/owner and go to ISSUE; otherwise it stays in IDLE.
REQ-019 When both j_pend and s_req_valid are asserted, the grant SHALL be round-robin: the requester not granted last wins; after reset, JTAG wins first.
REQ-020 s_req_ready SHALL be combinational, asserted only in IDLE on the cycle the system port is granted (handshake = s_req_valid & s_req_ready).
REQ-021 ISSUE: dm_req SHALL be 1 for exactly one cycle with latched dm_wr/dm_addr/dm_wdata; the FSM then goes to WAIT.
REQ-022 WAIT: on dm_rsp_valid, the FSM SHALL register dm_rdata into the owner's rdata, pulse the owner's done/rsp_valid with err=0 on the next cycle, and return to IDLE.
REQ-023 WAIT: the timeout counter SHALL clear on entering WAIT and increment each cycle; on count==TIMEOUT without a response, the owner SHALL receive a response with rdata=0 and err=1, and the FSM returns to IDLE.
REQ-024 dm_rsp_valid outside WAIT SHALL be ignored; dm_rsp_valid on the same cycle as timeout SHALL be treated as a normal response (err=0).
REQ-025 Latency: grant at cycle N, dm_req at N+1, response at cycle M, owner response pulse at M+1; the next grant SHALL NOT occur before M+1.
REQ-026 dm_wr/dm_addr/dm_wdata and j_rdata/s_rdata/err SHALL hold their values until overwritten by the next grant or response respectively.

Reset
REQ-027 On rst_n=0, the FSM SHALL go to IDLE; j_pend, j_overrun, the round-robin pointer (favouring JTAG), the counter and all outputs SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse, and a late dm_rsp_valid after reset SHALL be ignored.

Verification
REQ-029 Single JTAG read, addr 0x11: j_reg_en pulse; dm_rsp_valid 3 cycles after dm_req with 0xDEADBEEF -> dm_req 1 cycle after grant, j_done pulse with j_rdata=0xDEADBEEF, j_err=0, j_busy drops.
REQ-030 Simultaneous j_reg_en and s_req_valid after reset -> JTAG is served first, system second; with both continuously re-requesting, grants strictly alternate.
REQ-031 System write, addr 0x10, data 0x1: dm never responds, TIMEOUT=4 -> s_rsp_valid 5 cycles after entering WAIT, with s_rsp_err=1 and s_rdata=0.
REQ-032 Second j_reg_en while the first is in WAIT -> j_overrun=1, and exactly one dm_req is issued for JTAG.
REQ-033 rst_n pulsed low during WAIT, then dm_rsp_valid -> no j_done/s_rsp_valid, FSM in IDLE, all outputs 0.
REQ-034 dm_rsp_valid on the same cycle the counter reaches TIMEOUT -> response delivered with err=0 and the correct rdata.
